// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with registered grant, one idle cycle between grants.
// Define ARB_TIMEOUT_EN to force release of a grant held for TIMEOUT busy cycles.
module rr_arbiter_8 #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       EN,
    input  logic [7:0] Req,
    output logic [7:0] Gnt,
    output logic [2:0] Y,
    output logic       Valid,
    output logic       Done,
    output logic       Tout
);

    localparam logic StIdle = 1'b0;
    localparam logic StBusy = 1'b1;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("rr_arbiter_8: TIMEOUT must be in 1..255");
    end

    logic       state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] y_q, y_d;
    logic       valid_q, valid_d;
    logic       done_q, done_d;
    logic       drop;
    logic       found;
    logic [2:0] pick;
    logic [2:0] cand;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);
    logic [7:0] cnt_q, cnt_d;
    logic       tout_q, tout_d;
`endif

    // Rotating priority search: first set request at or after the pointer.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = ptr_q;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!found && Req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        y_d     = y_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        drop    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        tout_d  = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (!EN && found) begin
                    state_d = StBusy;
                    gnt_d   = 8'b1 << pick;
                    y_d     = pick;
                    valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            default: begin
                if (EN) begin
                    drop = 1'b1;
                end else if (!Req[y_q]) begin
                    drop  = 1'b1;
                    ptr_d = y_q + 3'd1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q + 8'd1 == TimeoutVal) begin
                    drop   = 1'b1;
                    tout_d = 1'b1;
                    ptr_d  = y_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
        endcase
        if (drop) begin
            state_d = StIdle;
            gnt_d   = 8'd0;
            y_d     = 3'd0;
            valid_d = 1'b0;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= 3'd0;
            gnt_q   <= 8'd0;
            y_q     <= 3'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 8'd0;
            tout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tout_q <= tout_d;
        end
    end

    assign Tout = tout_q;
`else
    assign Tout = 1'b0;
`endif

    assign Gnt   = gnt_q;
    assign Y     = y_q;
    assign Valid = valid_q;
    assign Done  = done_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed self-checking bench for rr_arbiter_8 (default build, timeout section when
// ARB_TIMEOUT_EN is defined).
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic       EN;
    logic [7:0] Req;
    logic [7:0] Gnt;
    logic [2:0] Y;
    logic       Valid;
    logic       Done;
    logic       Tout;

    int n_cmp = 0;
    int n_err = 0;

    rr_arbiter_8 #(.TIMEOUT(15)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .EN   (EN),
        .Req  (Req),
        .Gnt  (Gnt),
        .Y    (Y),
        .Valid(Valid),
        .Done (Done),
        .Tout (Tout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] eg, input logic [2:0] ey,
                         input logic ev, input logic ed, input logic et);
        n_cmp++;
        assert ({Gnt, Y, Valid, Done, Tout} === {eg, ey, ev, ed, et})
        else begin
            n_err++;
            $error("FAIL %s: got gnt=%b y=%0d valid=%b done=%b tout=%b, want gnt=%b y=%0d valid=%b done=%b tout=%b",
                   tag, Gnt, Y, Valid, Done, Tout, eg, ey, ev, ed, et);
        end
    endtask

    task automatic check_grant(input string tag, input int idx);
        logic [7:0] g;
        g = 8'b1 << idx;
        check(tag, g, 3'(idx), 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        EN    = 1'b1;
        Req   = 8'd0;
        #12;
        check("reset_state", 8'd0, 3'd0, 1'b0, 1'b0, 1'b0);

        // Basic grant and release from requester 0
        tick();
        rst_n = 1'b1;
        EN    = 1'b0;
        Req   = 8'b0000_0001;
        tick();
        check_grant("first_grant_0", 0);
        Req = 8'd0;
        tick();
        check("release_0_done", 8'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        check("done_one_cycle", 8'd0, 3'd0, 1'b0, 1'b0, 1'b0);

        // Alternation between 1 and 7 with an idle cycle between grants (ptr=1 here)
        Req = 8'b1000_0010;
        tick();
        check_grant("alt_grant_1a", 1);
        Req = 8'b1000_0000;
        tick();
        check("alt_idle_a", 8'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        Req = 8'b1000_0010;
        tick();
        check_grant("alt_grant_7a", 7);
        Req = 8'b0000_0010;
        tick();
        check("alt_idle_b", 8'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        Req = 8'b1000_0010;
        tick();
        check_grant("alt_grant_1b", 1);
        Req = 8'b1000_0000;
        tick();
        check("alt_idle_c", 8'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        Req = 8'b1000_0010;
        tick();
        check_grant("alt_grant_7b", 7);
        Req = 8'd0;
        tick();
        check("alt_release_7", 8'd0, 3'd0, 1'b0, 1'b1, 1'b0);

        // All requesting: pointer walks 0..7 and wraps back to 0
        Req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            tick();
            check_grant($sformatf("ff_grant_%0d", k), k % 8);
            tick();
            check_grant($sformatf("ff_hold_%0d", k), k % 8);
            Req = 8'hFF & ~(8'b1 << (k % 8));
            tick();
            check($sformatf("ff_release_%0d", k), 8'd0, 3'd0, 1'b0, 1'b1, 1'b0);
            Req = 8'hFF;
        end
        Req = 8'd0;
        tick();
        check("idle_no_req", 8'd0, 3'd0, 1'b0, 1'b0, 1'b0);

        // Move pointer to 3, then disable mid-grant: pointer must stay at 3
        Req = 8'b0000_0100;
        tick();
        check_grant("ptr_setup_2", 2);
        Req = 8'd0;
        tick();
        check("ptr_setup_rel", 8'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        Req = 8'hFF;
        tick();
        check_grant("en_grant_3", 3);
        EN = 1'b1;
        tick();
        check("en_disable_done", 8'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        check("en_disabled_idle", 8'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        EN = 1'b0;
        tick();
        check_grant("en_regrant_3", 3);
        Req = 8'hF7;
        tick();
        check("rel_3", 8'd0, 3'd0, 1'b0, 1'b1, 1'b0);

        // Request pulse entirely between edges is ignored
        Req = 8'd0;
        tick();
        Req = 8'b0010_0000;
        #2;
        Req = 8'd0;
        tick();
        check("glitch_ignored", 8'd0, 3'd0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-grant on 5 (ptr=4 here)
        Req = 8'b0010_0000;
        tick();
        check_grant("pre_reset_5", 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", 8'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("reset_no_done", 8'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        Req   = 8'hFF;
        tick();
        check_grant("post_reset_ptr0", 0);
        Req = 8'd0;
        tick();
        check("post_reset_rel", 8'd0, 3'd0, 1'b0, 1'b1, 1'b0);

        // Long hold on requester 2 (ptr=1 here)
        Req = 8'b0000_1100;
        tick();
        check_grant("hold_grant_2", 2);
`ifdef ARB_TIMEOUT_EN
        for (int c = 2; c <= 15; c++) begin
            tick();
            check_grant($sformatf("to_busy_%0d", c), 2);
        end
        tick();
        check("timeout_release", 8'd0, 3'd0, 1'b0, 1'b1, 1'b1);
        tick();
        check_grant("timeout_next_3", 3);
`else
        for (int c = 2; c <= 20; c++) begin
            tick();
            check_grant($sformatf("hold_busy_%0d", c), 2);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
